// File: rtl/sensor_read_arbiter_pkg.sv
// sensor_pkg: shared types for the sensor read arbiter.
//   mode_e      - per-channel sensor mode written through the config port
//   status_e    - sensor status code reported alongside each result
//   arb_state_e - arbiter FSM states
//   cfg_to_mode - maps a raw config mode to a legal mode (3 -> STOP)
package sensor_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_FAST = 2'd1,
    MODE_SLOW = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    STAT_STOP = 3'd0,
    STAT_IDLE = 3'd1,
    STAT_FAST = 3'd2,
    STAT_SLOW = 3'd3
  } status_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // The unused encoding 3 is never stored; it falls back to STOP.
  function automatic mode_e cfg_to_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_STOP : mode_e'(m);
  endfunction

endpackage

// File: rtl/sensor_read_arbiter_if.sv
// Bundle of sensor, configuration and CPU-side signals of the arbiter.
//   slave  - arbiter view: sensor/config/CPU inputs in, mode/enable/result out
//   master - environment view (sensors, config writer, CPU)
// Sensor side : SensorValReady, SensorResult, SensorErrorCode -> arbiter
//               SensorMode, SensorEnable, SensorReadComplete  <- arbiter
// Config side : CfgWrite, CfgChannel, CfgMode, CfgEnable      -> arbiter
// CPU side    : DataValid, DataOut, DataChannel, DataErr      <- arbiter
//               CpuAck -> arbiter;  TimeoutFlag <- arbiter
interface sensor_read_arbiter_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned RESULT_W = 16
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]               SensorValReady;
  logic [NUM_CH-1:0][RESULT_W-1:0] SensorResult;
  logic [NUM_CH-1:0][2:0]          SensorErrorCode;
  logic [NUM_CH-1:0][1:0]          SensorMode;
  logic [NUM_CH-1:0]               SensorEnable;
  logic [NUM_CH-1:0]               SensorReadComplete;

  logic                            CfgWrite;
  logic [CH_W-1:0]                 CfgChannel;
  logic [1:0]                      CfgMode;
  logic                            CfgEnable;

  logic                            DataValid;
  logic [RESULT_W-1:0]             DataOut;
  logic [CH_W-1:0]                 DataChannel;
  logic [2:0]                      DataErr;
  logic                            CpuAck;
  logic [NUM_CH-1:0]               TimeoutFlag;

  modport slave (
    input  SensorValReady, SensorResult, SensorErrorCode,
    input  CfgWrite, CfgChannel, CfgMode, CfgEnable, CpuAck,
    output SensorMode, SensorEnable, SensorReadComplete,
    output DataValid, DataOut, DataChannel, DataErr, TimeoutFlag
  );

  modport master (
    output SensorValReady, SensorResult, SensorErrorCode,
    output CfgWrite, CfgChannel, CfgMode, CfgEnable, CpuAck,
    input  SensorMode, SensorEnable, SensorReadComplete,
    input  DataValid, DataOut, DataChannel, DataErr, TimeoutFlag
  );

endinterface

// File: rtl/sensor_read_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority search.
//   req_i   - request vector
//   last_i  - index of the previous grant; search starts at last_i+1
//   grant_o - one-hot grant
//   valid_o - at least one request was found
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] last_i,
  output logic [NUM_CH-1:0]         grant_o,
  output logic                      valid_o
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0] idx;

  // NUM_CH is a power of two, so the index adder wraps modulo NUM_CH by
  // itself; the last offset (NUM_CH) lands back on last_i.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      idx = last_i + CH_W'(off);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_read_arbiter.sv
// sensor_read_arbiter: round-robin reader of NUM_CH sensor results.
// A channel requests when its sensor flags a ready value and it is enabled.
// The granted result is held for the CPU until acknowledged, then the
// sensor is told the read is complete until it drops its ready flag or
// RELEASE_TIMEOUT cycles pass (timeout sets a sticky flag).
//   Clk   - clock, rising edge
//   Rst_n - asynchronous active-low reset
//   bus   - sensor / config / CPU signal bundle (slave modport)
module sensor_read_arbiter
  import sensor_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned RESULT_W        = 16,
  parameter int unsigned RELEASE_TIMEOUT = 8
) (
  input logic                   Clk,
  input logic                   Rst_n,
  sensor_read_arbiter_if.slave  bus
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(RELEASE_TIMEOUT + 1);

  arb_state_e               state_q, state_d;
  logic [CH_W-1:0]          last_q, last_d;
  logic [CH_W-1:0]          chan_q, chan_d;
  logic [RESULT_W-1:0]      data_q, data_d;
  logic [2:0]               err_q, err_d;
  logic [NUM_CH-1:0]        en_q, en_d;
  logic [NUM_CH-1:0][1:0]   mode_q, mode_d;
  logic [NUM_CH-1:0]        flag_q, flag_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        grant_oh;
  logic                     grant_vld;
  logic [CH_W-1:0]          gidx;
  logic                     gnt_disable;
  logic                     rel_timeout;

  // Registered enables only: a same-cycle config write cannot alter a grant.
  assign req = bus.SensorValReady & en_q;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (grant_oh),
    .valid_o (grant_vld)
  );

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i]) gidx = CH_W'(i);
    end
  end

  // A disable being written this cycle counts as a disable already, so that
  // DataValid drops on the next edge and wins over a simultaneous CpuAck.
  assign gnt_disable = !en_q[chan_q] ||
                       (bus.CfgWrite && (bus.CfgChannel == chan_q) && !bus.CfgEnable);
  assign rel_timeout = (cnt_q == CNT_W'(RELEASE_TIMEOUT - 1));

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = PRESENT;
      PRESENT: begin
        if (gnt_disable)     state_d = IDLE;
        else if (bus.CpuAck) state_d = RELEASE;
      end
      RELEASE: if (!bus.SensorValReady[chan_q] || rel_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.DataValid          = 1'b0;
    bus.SensorReadComplete = '0;
    case (state_q)
      PRESENT: bus.DataValid = 1'b1;
      RELEASE: bus.SensorReadComplete[chan_q] = 1'b1;
      default: ;
    endcase
  end

  // Datapath and configuration next-state
  always_comb begin
    last_d = last_q;
    chan_d = chan_q;
    data_d = data_q;
    err_d  = err_q;
    en_d   = en_q;
    mode_d = mode_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          last_d = gidx;
          chan_d = gidx;
          data_d = bus.SensorResult[gidx];
          err_d  = bus.SensorErrorCode[gidx];
        end
      end
      PRESENT: cnt_d = '0;
      RELEASE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.SensorValReady[chan_q] && rel_timeout) flag_d[chan_q] = 1'b1;
      end
      default: ;
    endcase
    if (bus.CfgWrite) begin
      en_d[bus.CfgChannel]   = bus.CfgEnable;
      mode_d[bus.CfgChannel] = cfg_to_mode(bus.CfgMode);
      flag_d[bus.CfgChannel] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_q <= CH_W'(NUM_CH - 1);
      chan_q <= '0;
      data_q <= '0;
      err_q  <= '0;
      en_q   <= '0;
      mode_q <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      chan_q <= chan_d;
      data_q <= data_d;
      err_q  <= err_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.DataOut      = data_q;
  assign bus.DataChannel  = chan_q;
  assign bus.DataErr      = err_q;
  assign bus.SensorEnable = en_q;
  assign bus.SensorMode   = mode_q;
  assign bus.TimeoutFlag  = flag_q;

endmodule

// File: tb/tb_sensor_read_arbiter.sv
module tb_sensor_read_arbiter;

  logic Clk;
  logic Rst_n;

  sensor_read_arbiter_if #(.NUM_CH(4), .RESULT_W(16)) bus ();

  sensor_read_arbiter #(
    .NUM_CH          (4),
    .RESULT_W        (16),
    .RELEASE_TIMEOUT (8)
  ) u_dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        cw;
    logic [1:0]  cch;
    logic [1:0]  cmode;
    logic        cen;
    logic [3:0]  vr;
    logic        ack;
    logic        e_dv;
    logic [1:0]  e_ch;
    logic [15:0] e_do;
    logic [3:0]  e_rc;
    logic [3:0]  e_en;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0] exp_err [4];

  function automatic vec_t mk(input logic rst, input logic cw, input logic [1:0] cch,
                              input logic [1:0] cmode, input logic cen, input logic [3:0] vr,
                              input logic ack, input logic e_dv, input logic [1:0] e_ch,
                              input logic [15:0] e_do, input logic [3:0] e_rc,
                              input logic [3:0] e_en);
    vec_t v;
    v.rst = rst; v.cw = cw; v.cch = cch; v.cmode = cmode; v.cen = cen;
    v.vr = vr; v.ack = ack; v.e_dv = e_dv; v.e_ch = e_ch; v.e_do = e_do;
    v.e_rc = e_rc; v.e_en = e_en;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] mode, input logic en);
    bus.CfgWrite = 1'b1; bus.CfgChannel = ch; bus.CfgMode = mode; bus.CfgEnable = en;
    tick();
    bus.CfgWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_err[0] = 3'd1; exp_err[1] = 3'd3; exp_err[2] = 3'd2; exp_err[3] = 3'd1;

    Rst_n = 1'b0;
    bus.SensorValReady = '0;
    bus.SensorResult[0] = 16'h1100;
    bus.SensorResult[1] = 16'h006B;
    bus.SensorResult[2] = 16'h2200;
    bus.SensorResult[3] = 16'h3300;
    for (int i = 0; i < 4; i++) bus.SensorErrorCode[i] = exp_err[i];
    bus.CfgWrite = 1'b0; bus.CfgChannel = '0; bus.CfgMode = '0; bus.CfgEnable = 1'b0;
    bus.CpuAck = 1'b0;

    //           rst cw  ch    md    en   vr       ack  dv  ch    do        rc       en
    vecs.push_back(mk(1, 1, 2'd1, 2'd2, 1, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0010, 0,  1, 2'd1, 16'h006B, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0010, 0,  1, 2'd1, 16'h006B, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0010, 1,  0, 2'd0, 16'h0000, 4'b0010, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0010, 0,  0, 2'd0, 16'h0000, 4'b0010, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b0010));
    vecs.push_back(mk(0, 0, 2'd0, 2'd0, 0, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 1, 2'd0, 2'd1, 1, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 1, 2'd1, 2'd1, 1, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b0011));
    vecs.push_back(mk(1, 1, 2'd2, 2'd1, 1, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b0111));
    vecs.push_back(mk(1, 1, 2'd3, 2'd1, 1, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 0,  1, 2'd0, 16'h1100, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 1,  0, 2'd0, 16'h0000, 4'b0001, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1110, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 0,  1, 2'd1, 16'h006B, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 1,  0, 2'd0, 16'h0000, 4'b0010, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1101, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 0,  1, 2'd2, 16'h2200, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 1,  0, 2'd0, 16'h0000, 4'b0100, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1011, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 0,  1, 2'd3, 16'h3300, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 1,  0, 2'd0, 16'h0000, 4'b1000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0111, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 0,  1, 2'd0, 16'h1100, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b1111, 1,  0, 2'd0, 16'h0000, 4'b0001, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0000, 1,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 1, 2'd2, 2'd1, 0, 4'b0100, 0,  1, 2'd2, 16'h2200, 4'b0000, 4'b1011));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 0, 4'b0100, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1011));
    vecs.push_back(mk(1, 1, 2'd2, 2'd1, 1, 4'b0000, 0,  0, 2'd0, 16'h0000, 4'b0000, 4'b1111));

    tick(); tick();
    chk("rst_dv",   32'(bus.DataValid), 0);
    chk("rst_rc",   32'(bus.SensorReadComplete), 0);
    chk("rst_en",   32'(bus.SensorEnable), 0);
    chk("rst_mode", 32'(bus.SensorMode), 0);
    chk("rst_flag", 32'(bus.TimeoutFlag), 0);
    chk("rst_data", {11'd0, bus.DataErr, bus.DataChannel, bus.DataOut}, 0);

    foreach (vecs[k]) begin
      Rst_n              = vecs[k].rst;
      bus.CfgWrite       = vecs[k].cw;
      bus.CfgChannel     = vecs[k].cch;
      bus.CfgMode        = vecs[k].cmode;
      bus.CfgEnable      = vecs[k].cen;
      bus.SensorValReady = vecs[k].vr;
      bus.CpuAck         = vecs[k].ack;
      tick();
      chk($sformatf("v%0d_dv", k), 32'(bus.DataValid), 32'(vecs[k].e_dv));
      chk($sformatf("v%0d_rc", k), 32'(bus.SensorReadComplete), 32'(vecs[k].e_rc));
      chk($sformatf("v%0d_en", k), 32'(bus.SensorEnable), 32'(vecs[k].e_en));
      if (vecs[k].e_dv) begin
        chk($sformatf("v%0d_ch", k),  32'(bus.DataChannel), 32'(vecs[k].e_ch));
        chk($sformatf("v%0d_do", k),  32'(bus.DataOut), 32'(vecs[k].e_do));
        chk($sformatf("v%0d_err", k), 32'(bus.DataErr), 32'(exp_err[vecs[k].e_ch]));
      end
    end
    bus.CfgWrite = 1'b0; bus.CpuAck = 1'b0; bus.SensorValReady = '0;
    chk("mode_all_fast", 32'(bus.SensorMode), 32'h55);

    // Release timeout on ch2
    bus.SensorValReady = 4'b0100;
    tick();
    chk("to_grant_ch", 32'(bus.DataChannel), 2);
    bus.CpuAck = 1'b1;
    tick();
    bus.CpuAck = 1'b0;
    n = 0;
    while (bus.SensorReadComplete == 4'b0100 && n < 20) begin
      n++;
      tick();
    end
    bus.SensorValReady = '0;
    chk("to_release_cycles", 32'(n), 8);
    chk("to_flag_set", 32'(bus.TimeoutFlag), 32'h4);
    cfg(2'd2, 2'd1, 1'b1);
    chk("to_flag_clear", 32'(bus.TimeoutFlag), 0);

    // Disable ch1 in PRESENT together with CpuAck; illegal mode reads as STOP
    bus.SensorValReady = 4'b0010;
    tick();
    chk("dis_grant_dv", 32'(bus.DataValid), 1);
    chk("dis_grant_ch", 32'(bus.DataChannel), 1);
    bus.CpuAck = 1'b1;
    cfg(2'd1, 2'd3, 1'b0);
    bus.CpuAck = 1'b0;
    chk("dis_dv", 32'(bus.DataValid), 0);
    chk("dis_mode", 32'(bus.SensorMode[1]), 0);
    chk("dis_en", 32'(bus.SensorEnable[1]), 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dis_rc%0d", i), 32'(bus.SensorReadComplete), 0);
      tick();
    end
    bus.SensorValReady = '0;

    // Disable ch3 while in RELEASE: release still completes
    bus.SensorValReady = 4'b1000;
    tick();
    chk("rel_grant_ch", 32'(bus.DataChannel), 3);
    bus.CpuAck = 1'b1;
    tick();
    bus.CpuAck = 1'b0;
    chk("rel_rc0", 32'(bus.SensorReadComplete), 32'h8);
    cfg(2'd3, 2'd1, 1'b0);
    chk("rel_rc1", 32'(bus.SensorReadComplete), 32'h8);
    bus.SensorValReady = '0;
    tick();
    chk("rel_done", 32'(bus.SensorReadComplete), 0);

    // Reset during RELEASE, then ch0 wins first
    cfg(2'd1, 2'd2, 1'b1);
    cfg(2'd3, 2'd1, 1'b1);
    bus.SensorValReady = 4'b0010;
    tick();
    chk("ar_grant_ch", 32'(bus.DataChannel), 1);
    bus.CpuAck = 1'b1;
    tick();
    bus.CpuAck = 1'b0;
    chk("ar_rc", 32'(bus.SensorReadComplete), 32'h2);
    #2 Rst_n = 1'b0;
    #1;
    chk("ar_dv",   32'(bus.DataValid), 0);
    chk("ar_rc0",  32'(bus.SensorReadComplete), 0);
    chk("ar_en",   32'(bus.SensorEnable), 0);
    chk("ar_mode", 32'(bus.SensorMode), 0);
    chk("ar_data", {11'd0, bus.DataErr, bus.DataChannel, bus.DataOut}, 0);
    tick();
    Rst_n = 1'b1;
    bus.SensorValReady = '0;
    cfg(2'd2, 2'd1, 1'b1);
    cfg(2'd0, 2'd1, 1'b1);
    bus.SensorValReady = 4'b0101;
    tick();
    chk("ar_first_dv", 32'(bus.DataValid), 1);
    chk("ar_first_ch", 32'(bus.DataChannel), 0);
    chk("ar_first_do", 32'(bus.DataOut), 32'h1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_read_arbiter.md
SENSOR_READ_ARBITER -- requirements
Module: sensor_read_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of sensor channels served (power of two, 2..8).
REQ-002 The block SHALL have parameter RESULT_W, default 16, meaning the width of each sensor result.
REQ-003 The block SHALL have parameter RELEASE_TIMEOUT, default 8, meaning the maximum number of RELEASE cycles spent waiting for a sensor to drop ValReady.
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 SensorValReady  input  NUM_CH  per-channel "value ready" flag from each sensor block.
REQ-007 SensorResult  input  NUM_CH x RESULT_W  per-channel measurement result.
REQ-008 SensorErrorCode  input  NUM_CH x 3  per-channel status code (0 Stop, 1 Idle, 2 Fast, 3 Slow).
REQ-009 SensorMode  output  NUM_CH x 2  per-channel mode (0 Stop, 1 Fast, 2 Slow).
REQ-010 SensorEnable  output  NUM_CH  per-channel enable.
REQ-011 SensorReadComplete  output  NUM_CH  per-channel "CPU read complete" strobe back to the sensor.
REQ-012 CfgWrite  input  1  one-cycle configuration write strobe.
REQ-013 CfgChannel  input  log2(NUM_CH)  channel addressed by CfgWrite.
REQ-014 CfgMode  input  2  mode written to the addressed channel; value 3 is illegal.
REQ-015 CfgEnable  input  1  enable written to the addressed channel.
REQ-016 DataValid  output  1  presented result is valid for the CPU.
REQ-017 DataOut / DataChannel / DataErr  output  RESULT_W / log2(NUM_CH) / 3  latched result, its source channel and its status code.
REQ-018 CpuAck  input  1  CPU has consumed the presented result.
REQ-019 TimeoutFlag  output  NUM_CH  sticky per-channel release-timeout indication.

Function
REQ-020 The FSM SHALL have the states IDLE, PRESENT and RELEASE.
REQ-021 In IDLE, a channel SHALL request when SensorValReady[i]=1 and registered SensorEnable[i]=1.
REQ-022 Arbitration SHALL be round-robin, searching from (LastGrant+1) mod NUM_CH upward with wrap-around.
REQ-023 On the grant edge the block SHALL latch SensorResult, SensorErrorCode and the channel index into DataOut, DataErr and DataChannel, enter PRESENT and set LastGrant; DataValid SHALL be 1 in the cycle after the request is sampled.
REQ-024 DataOut, DataErr and DataChannel SHALL remain stable while DataValid=1.
REQ-025 In PRESENT with CpuAck=1 the FSM SHALL enter RELEASE and deassert DataValid on the next cycle; CpuAck outside PRESENT SHALL be ignored.
REQ-026 In RELEASE, SensorReadComplete[g] SHALL be 1 for the granted channel g only, and all other SensorReadComplete bits SHALL be 0.
REQ-027 RELEASE SHALL exit to IDLE in the first cycle SensorValReady[g]=0 or after RELEASE_TIMEOUT cycles, whichever comes first.
REQ-028 A RELEASE exit by timeout SHALL set TimeoutFlag[g].
REQ-029 A CfgWrite to channel i SHALL clear TimeoutFlag[i].
REQ-030 A CfgWrite SHALL update SensorMode[CfgChannel] and SensorEnable[CfgChannel] on the next edge in any FSM state.
REQ-031 A CfgWrite with CfgMode=3 SHALL write Stop (0) instead.
REQ-032 Arbitration SHALL use the registered enables, so a CfgWrite in the same cycle as a grant does not affect that grant.
REQ-033 If the granted channel is disabled while in PRESENT, the FSM SHALL drop DataValid and return to IDLE without asserting SensorReadComplete.
REQ-034 If the granted channel is disabled while in RELEASE, the release SHALL still complete normally.
REQ-035 CpuAck arriving in the same cycle as a disable of the granted channel SHALL be treated as the disable.

Reset
REQ-036 While Rst_n=0, the FSM SHALL be in IDLE and LastGrant SHALL be NUM_CH-1.
REQ-037 While Rst_n=0, DataValid, DataOut, DataChannel, DataErr, SensorReadComplete, TimeoutFlag, SensorEnable and SensorMode SHALL all be 0.
REQ-038 A reset asserted mid-transaction SHALL abandon the transaction immediately with no SensorReadComplete pulse.

Structure
REQ-039 Shared package sensor_pkg SHALL hold the mode enum (STOP=0, FAST=1, SLOW=2), the status-code enum (0-3) and the arbiter state enum.
REQ-040 The round-robin priority search SHALL be a sub-module rr_arbiter (request vector + last grant in -> one-hot grant + valid out, combinational).

Verification
REQ-041 Reset, then write ch1 Enable=1 Mode=Slow, hold ValReady[1]=1, Result[1]=16'h006B -> DataValid=1 one cycle later, DataOut=16'h006B, DataChannel=1, DataErr=Result status.
REQ-042 With DataValid=1, pulse CpuAck; sensor drops ValReady[1] two cycles later -> ReadComplete[1] high for exactly those RELEASE cycles, then IDLE.
REQ-043 Enable ch0-ch3, all ValReady=1 continuously, CPU acks each result -> grant order 0,1,2,3,0.
REQ-044 Hold ValReady[2]=1 through RELEASE -> exit after 8 cycles with TimeoutFlag[2]=1; a CfgWrite to ch2 clears it.
REQ-045 Disable ch1 via CfgWrite while ch1 is in PRESENT -> DataValid=0 next cycle, ReadComplete[1] never asserted; a CfgWrite with CfgMode=3 reads back SensorMode=0.
REQ-046 Pull Rst_n low during RELEASE -> all outputs 0 immediately (asynchronously); after release, ch0 is granted first.
